pad_input_filter: RTL and testbench

Synchronises and debounces the asynchronous receive value driven by a functional I/O pad's `O` output, producing a clean, glitch-free level and optional edge pulses for core logic. It sits directly downstream of the pad cell. Input-only pads and bidirectional pads in receive mode feed it. It contains a two-flop synchroniser, a stability counter and a small FSM.

---
 rtl/pad_input_filter_pkg.sv | 12 +
 rtl/pad_input_sync.sv | 31 +++
 rtl/pad_input_filter.sv | 124 ++++++++++++
 tb/tb_pad_input_filter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pad_input_filter_pkg.sv
// Shared types and constants for the pad input synchroniser / debounce filter.
package pad_input_filter_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } filt_state_e;

    localparam int unsigned PadFilterMinCycles = 2;
    localparam int unsigned PadFilterMaxCycles = 65535;

endpackage

// File: rtl/pad_input_sync.sv
// Two-flop synchroniser for the asynchronous pad receive value.
module pad_input_sync #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d_i;
        s2_d = s1_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= RESET_VALUE;
            s2_q <= RESET_VALUE;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pad_input_filter.sv
// Synchronises and debounces a pad receive value into a clean level with optional edge pulses.
// Edge pulses are built only when PAD_INPUT_FILTER_EDGE_EN is defined; otherwise rise_o/fall_o are 0.
module pad_input_filter
    import pad_input_filter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    input  logic filt_en_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < PadFilterMinCycles || DEBOUNCE_CYCLES > PadFilterMaxCycles) begin : g_bad_cfg
            $error("pad_input_filter: DEBOUNCE_CYCLES out of range 2..65535");
        end
    endgenerate

    logic        s2;
    filt_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic        level_q, level_d;

    pad_input_sync #(
        .RESET_VALUE(RESET_VALUE)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (pad_i),
        .q_o  (s2)
    );

    // Candidate qualification: the compare always uses the current s2, so a
    // return to the old value on the expiry cycle cancels the flip.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!filt_en_i) begin
            state_d = STABLE;
            cnt_d   = '0;
            level_d = s2;
        end else begin
            case (state_q)
                STABLE: begin
                    if (s2 != level_q) begin
                        state_d = CHECK;
                        cnt_d   = CntW'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                CHECK: begin
                    if (s2 == level_q) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        level_d = s2;
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    assign busy_o  = (state_q == CHECK);

`ifdef PAD_INPUT_FILTER_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Pulses register alongside level_q so they line up with the new level.
    always_comb begin
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_pad_input_filter.sv
// Scoreboard bench for pad_input_filter: two instances (reset value 0 and 1), debounce of 4.
module tb_pad_input_filter;

    logic clk;
    logic rst;
    logic pad_a, filt_a, level_a, rise_a, fall_a, busy_a;
    logic pad_b, filt_b, level_b, rise_b, fall_b, busy_b;

    int unsigned cyc;
    int checks;
    int errors;

    typedef struct {
        int unsigned cyc;
        bit          dut;
        logic [3:0]  outs;   // {level, rise, fall, busy}
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    logic [3:0] act;

    pad_input_filter #(.DEBOUNCE_CYCLES(4), .RESET_VALUE(1'b0)) u_dut_a (
        .clk_i    (clk),
        .rst_i    (rst),
        .pad_i    (pad_a),
        .filt_en_i(filt_a),
        .level_o  (level_a),
        .rise_o   (rise_a),
        .fall_o   (fall_a),
        .busy_o   (busy_a)
    );

    pad_input_filter #(.DEBOUNCE_CYCLES(4), .RESET_VALUE(1'b1)) u_dut_b (
        .clk_i    (clk),
        .rst_i    (rst),
        .pad_i    (pad_b),
        .filt_en_i(filt_b),
        .level_o  (level_b),
        .rise_o   (rise_b),
        .fall_o   (fall_b),
        .busy_o   (busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic ed(input logic v);
        logic r;
        r = v;
`ifndef PAD_INPUT_FILTER_EDGE_EN
        r = 1'b0;
`endif
        return r;
    endfunction

    task automatic push(input int unsigned c, input bit d, input logic l, input logic r,
                        input logic f, input logic b, input string t);
        exp_t x;
        x.cyc  = c;
        x.dut  = d;
        x.outs = {l, r, f, b};
        x.tag  = t;
        sb_q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: compare every scheduled expectation at the falling edge of its cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            act = e.dut ? {level_b, rise_b, fall_b, busy_b} : {level_a, rise_a, fall_a, busy_a};
            checks++;
            if (e.cyc != cyc || act !== e.outs) begin
                errors++;
                $display("FAIL %s dut=%0d cyc=%0d exp_cyc=%0d got{lvl,rise,fall,busy}=%b exp=%b",
                         e.tag, e.dut, cyc, e.cyc, act, e.outs);
            end
        end
    end

    initial begin
        int unsigned k;
        int unsigned r;
        logic lv;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        pad_a  = 1'b0;
        pad_b  = 1'b1;
        filt_a = 1'b1;
        filt_b = 1'b1;

        push(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_a");
        push(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "reset_b");
        tick(2);
        rst = 1'b0;

        // Pull-up instance holds 1 for 50 cycles with pad high; A idles at 0.
        k = cyc;
        for (int i = 0; i <= 50; i++) begin
            push(k + i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_a");
            push(k + i, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "hold_high_b");
        end
        tick(51);

        // Three synchronised high samples then low: cancelled exactly at expiry.
        k = cyc;
        pad_a = 1'b1;
        for (int i = 0; i <= 9; i++)
            push(k + i, 1'b0, 1'b0, 1'b0, 1'b0, (i >= 3 && i <= 5), "glitch");
        tick(3);
        pad_a = 1'b0;
        tick(7);

        // Stable 0->1: busy from E+2, level and rise at E+5.
        k = cyc;
        pad_a = 1'b1;
        for (int i = 0; i <= 10; i++)
            push(k + i, 1'b0, (i >= 6), ed(i == 6), 1'b0, (i >= 3 && i <= 5), "rise_filt");
        tick(11);

        // Bypass: pad toggles every 3 cycles, level follows 3 cycles after the drive.
        k = cyc;
        filt_a = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            lv = (i < 6) ? 1'b1 : (((i - 6) / 3) % 2 == 1);
            push(k + i, 1'b0, lv,
                 ed(i >= 6 && (i - 6) % 3 == 0 && lv),
                 ed(i >= 6 && (i - 6) % 3 == 0 && !lv),
                 1'b0, "bypass");
        end
        tick(3); pad_a = 1'b0;
        tick(3); pad_a = 1'b1;
        tick(3); pad_a = 1'b0;
        tick(3); pad_a = 1'b1;
        tick(3); pad_a = 1'b0;
        tick(9);

        // Async reset mid-CHECK, then a full requalification after release.
        k = cyc;
        filt_a = 1'b1;
        pad_a  = 1'b1;
        for (int i = 0; i <= 3; i++)
            push(k + i, 1'b0, 1'b0, 1'b0, 1'b0, (i == 3), "pre_reset");
        for (int i = 4; i <= 6; i++)
            push(k + i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "in_reset");
        tick(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        r = cyc;
        for (int i = 1; i <= 10; i++)
            push(r + i, 1'b0, (i >= 6), ed(i == 6), 1'b0, (i >= 3 && i <= 5), "post_reset");
        tick(12);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick(1);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
